// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory line port between the I-cache and
// D-cache miss engines. One line transfer is in flight at a time; the granted
// request's address, operation and write data are captured at grant, and the
// memory response is routed back to the owning cache only.
//
// Build option: define PMEM_ARB_RR_EN to arbitrate round-robin between the two
// caches when both request in the same IDLE cycle. Without it the D-cache has
// fixed priority (a D miss stalls the whole pipeline, so it goes first).
//
// Handshake: a cache raises its request and holds it, with address/data
// stable, until it sees its one-cycle resp pulse; the arbiter ignores request
// inputs outside IDLE. Memory sees a strobe held high from the cycle after
// grant until (and including) the cycle pmem_resp=1, then one TURN cycle with
// both strobes low before the next grant can be issued.
//
// dbg_state / dbg_last_served_d expose the FSM state and round-robin history.

module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-cache side
  input  logic [ADDR_WIDTH-1:0] i_req_address,
  input  logic                  i_req_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // D-cache side
  input  logic [ADDR_WIDTH-1:0] d_req_address,
  input  logic                  d_req_read,
  input  logic                  d_req_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // memory side
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  // status
  output logic                  busy,
  output logic                  grant_d,
  // debug visibility
  output logic [1:0]            dbg_state,
  output logic                  dbg_last_served_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    TURN    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_d;      // 1: D-cache was served last, 0: I-cache
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_op_read;
  logic                  r_op_write;
  logic [LINE_WIDTH-1:0] r_wdata;

  logic                  w_d_req;
  logic                  w_pick_d;
  logic                  w_load_i;
  logic                  w_load_d;
  logic                  w_done_i;
  logic                  w_done_d;

  // A D request is either a refill read or a writeback write.
  assign w_d_req = d_req_read | d_req_write;

`ifdef PMEM_ARB_RR_EN
  // Round-robin: with both active, the one not served last wins; a lone
  // requester always wins.
  assign w_pick_d = w_d_req & (~i_req_read | ~r_last_d);
`else
  // Fixed priority: any D request beats the I-cache.
  assign w_pick_d = w_d_req;
`endif

  // State register and round-robin history; reset abandons any transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_done_d)      r_last_d <= 1'b1;
      else if (w_done_i) r_last_d <= 1'b0;
    end
  end

  // Next-state, grant strobes, memory strobes and response pulses.
  always_comb begin
    w_next_state = r_state;
    w_load_i     = 1'b0;
    w_load_d     = 1'b0;
    w_done_i     = 1'b0;
    w_done_d     = 1'b0;
    busy         = 1'b0;
    grant_d      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next_state = GRANT_D;
          w_load_d     = 1'b1;
        end else if (i_req_read) begin
          w_next_state = GRANT_I;
          w_load_i     = 1'b1;
        end
      end
      GRANT_I: begin
        busy       = 1'b1;
        pmem_read  = r_op_read;
        pmem_write = r_op_write;
        if (pmem_resp) begin
          i_resp       = 1'b1;
          w_done_i     = 1'b1;
          w_next_state = TURN;
        end
      end
      GRANT_D: begin
        busy       = 1'b1;
        grant_d    = 1'b1;
        pmem_read  = r_op_read;
        pmem_write = r_op_write;
        if (pmem_resp) begin
          d_resp       = 1'b1;
          w_done_d     = 1'b1;
          w_next_state = TURN;
        end
      end
      TURN: begin
        // Strobes low for one cycle so memory sees the edge; requesters
        // drop their request here.
        busy         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Capture the winning request at grant. When a D request carries both read
  // and write, the writeback wins; the D-cache re-requests the refill later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_op_read  <= 1'b0;
      r_op_write <= 1'b0;
      r_wdata    <= '0;
    end else if (w_load_d) begin
      r_addr     <= d_req_address;
      r_op_read  <= ~d_req_write;
      r_op_write <= d_req_write;
      r_wdata    <= d_req_write ? d_wdata : '0;
    end else if (w_load_i) begin
      r_addr     <= i_req_address;
      r_op_read  <= 1'b1;
      r_op_write <= 1'b0;
      r_wdata    <= '0;
    end
  end

  // Read data reaches only the owner, and only during its resp cycle.
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

  assign pmem_address      = r_addr;
  assign pmem_wdata        = r_wdata;
  assign dbg_state         = r_state;
  assign dbg_last_served_d = r_last_d;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: table of single transfers plus hand-written
// sequences for contention, mid-grant address change, reset mid-transfer and
// stray memory responses. Expected responses are queued when a request is
// driven and checked by a monitor when i_resp/d_resp pulse.

module tb_pmem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam int EW = 1 + LW + AW + 1 + LW;  // {is_d, rdata, addr, wr, wdata}

  logic          clk;
  logic          reset;
  logic [AW-1:0] i_req_address;
  logic          i_req_read;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic [AW-1:0] d_req_address;
  logic          d_req_read;
  logic          d_req_write;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic [AW-1:0] pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          busy;
  logic          grant_d;
  logic [1:0]    dbg_state;
  logic          dbg_last_served_d;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_req_address(i_req_address), .i_req_read(i_req_read),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_req_address(d_req_address), .d_req_read(d_req_read),
    .d_req_write(d_req_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy), .grant_d(grant_d),
    .dbg_state(dbg_state), .dbg_last_served_d(dbg_last_served_d)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic is_d, input logic [LW-1:0] rdata,
                                           input logic [AW-1:0] addr, input logic wr,
                                           input logic [LW-1:0] wdata);
    return {is_d, rdata, addr, wr, wdata};
  endfunction

  // Monitor: every resp pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (i_resp || d_resp) begin
      chk("resp_exclusive", LW'(i_resp & d_resp), LW'(0));
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", LW'({i_resp, d_resp}), LW'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_owner",  LW'(d_resp), LW'(mon_e[EW-1]));
        chk("owner_rdata", d_resp ? d_rdata : i_rdata, mon_e[2*LW+AW:LW+AW+1]);
        chk("other_rdata", d_resp ? i_rdata : d_rdata, LW'(0));
        chk("resp_addr",   LW'(pmem_address), LW'(mon_e[LW+AW:LW+1]));
        chk("resp_op",     LW'({pmem_read, pmem_write}), LW'({~mon_e[LW], mon_e[LW]}));
        if (mon_e[LW]) chk("resp_wdata", pmem_wdata, mon_e[LW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pmem_address"}, LW'(pmem_address), LW'(0));
    chk({tag, "_strobes"},      LW'({pmem_read, pmem_write}), LW'(0));
    chk({tag, "_pmem_wdata"},   pmem_wdata, LW'(0));
    chk({tag, "_resps"},        LW'({i_resp, d_resp}), LW'(0));
    chk({tag, "_busy_grant"},   LW'({busy, grant_d}), LW'(0));
    chk({tag, "_i_rdata"},      i_rdata, LW'(0));
    chk({tag, "_d_rdata"},      d_rdata, LW'(0));
    chk({tag, "_state"},        LW'(dbg_state), LW'(0));
  endtask

  // Plays memory for one transfer: waits for the strobe, holds resp off for
  // lat cycles, pulses pmem_resp, drops the owner's request in TURN.
  task automatic mem_serve(input logic exp_d, input logic exp_wr, input logic [AW-1:0] exp_addr,
                           input int lat, input logic [LW-1:0] rdata, input int exp_wait,
                           input logic do_chg, input logic [AW-1:0] chg_addr);
    int w = 0;
    while (!(pmem_read || pmem_write) && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      chk("grant_timeout", LW'(1), LW'(0));
      return;
    end
    if (exp_wait >= 0) chk("grant_latency", LW'(w), LW'(exp_wait));
    chk("grant_owner", LW'(grant_d), LW'(exp_d));
    chk("strobe_addr", LW'(pmem_address), LW'(exp_addr));
    chk("strobe_op",   LW'({pmem_read, pmem_write}), LW'({~exp_wr, exp_wr}));
    for (int k = 0; k < lat; k++) begin
      if (do_chg && k == 1) d_req_address = chg_addr;
      tick();
    end
    pmem_rdata = rdata;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = {4{$urandom}};
    if (exp_d) begin
      d_req_read  = 1'b0;
      d_req_write = 1'b0;
    end else begin
      i_req_read = 1'b0;
    end
    #1;
    chk("turn_state",   LW'(dbg_state), LW'(2'd3));
    chk("turn_strobes", LW'({pmem_read, pmem_write}), LW'(0));
    chk("turn_rdata",   i_rdata | d_rdata, LW'(0));
    tick();
  endtask

  typedef struct {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    logic ewr;
    ewr = v.is_d & v.wr;
    if (v.is_d) begin
      d_req_address = v.addr;
      d_wdata       = v.wdata;
      d_req_read    = v.rd;
      d_req_write   = v.wr;
    end else begin
      i_req_address = v.addr;
      i_req_read    = 1'b1;
    end
    exp_q.push_back(mk_exp(v.is_d, v.rdata, v.addr, ewr, v.wdata));
    mem_serve(v.is_d, ewr, v.addr, v.lat, v.rdata, 1, 1'b0, '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [LW-1:0] a5;
    logic [LW-1:0] f0;
    a5 = {16{8'hA5}};
    f0 = {16{8'h0F}};

    reset = 1'b1;
    i_req_address = '0; i_req_read = 1'b0;
    d_req_address = '0; d_req_read = 1'b0; d_req_write = 1'b0; d_wdata = '0;
    pmem_rdata = {4{$urandom}}; pmem_resp = 1'b0;

    vecs[0] = '{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 16'h1230, wdata: '0, rdata: a5, lat: 4};
    vecs[1] = '{is_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 16'h2340, wdata: '0, rdata: {16{8'h3C}}, lat: 0};
    vecs[2] = '{is_d: 1'b1, rd: 1'b0, wr: 1'b1, addr: 16'h3450, wdata: f0, rdata: {16{8'h77}}, lat: 2};
    vecs[3] = '{is_d: 1'b1, rd: 1'b1, wr: 1'b1, addr: 16'h6780, wdata: {16{8'h5A}}, rdata: {16{8'h11}}, lat: 1};
    vecs[4] = '{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 16'hFFF0, wdata: '0, rdata: '1, lat: 0};
    for (int i = 5; i < 8; i++) begin
      vecs[i].is_d  = 1'($urandom_range(0, 1));
      vecs[i].rd    = 1'($urandom_range(0, 1));
      vecs[i].wr    = 1'($urandom_range(0, 1));
      if (!vecs[i].rd && !vecs[i].wr) vecs[i].rd = 1'b1;
      vecs[i].addr  = AW'($urandom);
      vecs[i].wdata = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].rdata = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].lat   = $urandom_range(0, 5);
    end

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    chk("reset_last_served", LW'(dbg_last_served_d), LW'(0));
    reset = 1'b0;
    tick();

    // Single transfers from the table
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Stray memory response in IDLE is ignored
    pmem_resp = 1'b1;
    #1;
    chk("stray_resp", LW'({i_resp, d_resp}), LW'(0));
    tick();
    pmem_resp = 1'b0;
    chk("stray_state", LW'(dbg_state), LW'(0));

    // Contention: prior D read leaves last_served = D
    d_req_address = 16'h0A00; d_req_read = 1'b1;
    exp_q.push_back(mk_exp(1'b1, {16{8'h22}}, 16'h0A00, 1'b0, '0));
    mem_serve(1'b1, 1'b0, 16'h0A00, 1, {16{8'h22}}, 1, 1'b0, '0);
    chk("last_served_d", LW'(dbg_last_served_d), LW'(1));

    i_req_address = 16'h1111; i_req_read = 1'b1;
    d_req_address = 16'h8000; d_req_write = 1'b1; d_wdata = f0;
`ifdef PMEM_ARB_RR_EN
    exp_q.push_back(mk_exp(1'b0, {16{8'h44}}, 16'h1111, 1'b0, '0));
    exp_q.push_back(mk_exp(1'b1, {16{8'h33}}, 16'h8000, 1'b1, f0));
    mem_serve(1'b0, 1'b0, 16'h1111, 2, {16{8'h44}}, 1, 1'b0, '0);
    mem_serve(1'b1, 1'b1, 16'h8000, 3, {16{8'h33}}, -1, 1'b0, '0);
`else
    exp_q.push_back(mk_exp(1'b1, {16{8'h33}}, 16'h8000, 1'b1, f0));
    exp_q.push_back(mk_exp(1'b0, {16{8'h44}}, 16'h1111, 1'b0, '0));
    mem_serve(1'b1, 1'b1, 16'h8000, 3, {16{8'h33}}, 1, 1'b0, '0);
    mem_serve(1'b0, 1'b0, 16'h1111, 2, {16{8'h44}}, -1, 1'b0, '0);
`endif

    // Address change mid-grant does not disturb the transfer
    d_req_address = 16'h4000; d_req_read = 1'b1;
    exp_q.push_back(mk_exp(1'b1, {16{8'h66}}, 16'h4000, 1'b0, '0));
    mem_serve(1'b1, 1'b0, 16'h4000, 4, {16{8'h66}}, 1, 1'b1, 16'h5000);
    d_req_read = 1'b1;
    exp_q.push_back(mk_exp(1'b1, {16{8'h99}}, 16'h5000, 1'b0, '0));
    mem_serve(1'b1, 1'b0, 16'h5000, 1, {16{8'h99}}, 1, 1'b0, '0);

    // Reset during GRANT_D abandons the transfer
    d_req_address = 16'h7000; d_req_write = 1'b1; d_wdata = {16{8'hC3}};
    tick(); tick();
    chk("pre_reset_grant_d", LW'({grant_d, pmem_write}), LW'(2'b11));
    #2 reset = 1'b1;
    pmem_resp = 1'b1;
    #1;
    chk_all_zero("midreset");
    tick();
    pmem_resp = 1'b0;
    d_req_write = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_reset_idle", LW'({busy, dbg_state}), LW'(0));
    run_vec('{is_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 16'h0BC0, wdata: '0, rdata: {16{8'hE1}}, lat: 2});

    tick();
    chk("queue_empty", LW'(exp_q.size()), LW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
